hazard_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding unit for the 5-stage pipeline. It tracks in-flight writers (EX/MEM/WB) in an

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_scoreboard_src_match.sv | 48 ++++
 rtl/hazard_scoreboard.sv | 125 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding scoreboard.
// A stage record describes one in-flight instruction slot.
package hazard_pkg;

    localparam int MAX_REG_W = 8;
    localparam int REC_W     = MAX_REG_W + 3;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic                 v;
        logic [MAX_REG_W-1:0] rd;
        logic                 wr;
        logic                 load;
    } stage_rec_t;

    function automatic logic rec_hit(
        input stage_rec_t           r,
        input logic [MAX_REG_W-1:0] src,
        input logic                 used
    );
        return r.v & r.wr & used & (r.rd == src);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Per-source hazard check against the EX/MEM/WB shadow records.
// Produces the stall request and the EX operand select for one source.
module hzd_src_match
    import hazard_pkg::*;
#(
    parameter bit FWD_EN    = 1'b1,
    parameter bit RF_BYPASS = 1'b1
) (
    input  logic [MAX_REG_W-1:0] src_i,
    input  logic                 used_i,
    input  logic [REC_W-1:0]     ex_i,
    input  logic [REC_W-1:0]     mem_i,
    input  logic [REC_W-1:0]     wb_i,
    output logic                 stall_o,
    output logic [1:0]           fwd_sel_o
);

    stage_rec_t ex;
    stage_rec_t mem;
    stage_rec_t wb;
    logic       hit_ex;
    logic       hit_mem;
    logic       hit_wb;
    logic       unused_load;

    assign ex          = stage_rec_t'(ex_i);
    assign mem         = stage_rec_t'(mem_i);
    assign wb          = stage_rec_t'(wb_i);
    assign unused_load = mem.load ^ wb.load;

    assign hit_ex  = rec_hit(ex, src_i, used_i);
    assign hit_mem = rec_hit(mem, src_i, used_i);
    assign hit_wb  = rec_hit(wb, src_i, used_i);

    always_comb begin
        stall_o = (hit_ex & ex.load)
                | (!FWD_EN & (hit_ex | hit_mem))
                | (!RF_BYPASS & hit_wb);
        fwd_sel_o = FWD_RF;
        // youngest writer takes priority when EX and MEM share rd
        if (FWD_EN && hit_ex && !ex.load) begin
            fwd_sel_o = FWD_EXMEM;
        end else if (FWD_EN && hit_mem) begin
            fwd_sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: tracks in-flight writers in a shadow pipeline
// and decides stall / forward / RF read for the instruction in ID.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W     = 3,
    parameter bit FWD_EN    = 1'b1,
    parameter bit RF_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_rs_used,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             mem_stall,
    input  logic             flush,
    output logic             stall_id,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_rec_t       ex_q, ex_d;
    stage_rec_t       mem_q, mem_d;
    stage_rec_t       wb_q, wb_d;
    stage_rec_t       issue;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_a, stall_b;
    logic [1:0]       sel_a, sel_b;
    logic             advance;

    hzd_src_match #(
        .FWD_EN    (FWD_EN),
        .RF_BYPASS (RF_BYPASS)
    ) u_match_rs (
        .src_i     (MAX_REG_W'(id_rs)),
        .used_i    (id_rs_used),
        .ex_i      (ex_q),
        .mem_i     (mem_q),
        .wb_i      (wb_q),
        .stall_o   (stall_a),
        .fwd_sel_o (sel_a)
    );

    hzd_src_match #(
        .FWD_EN    (FWD_EN),
        .RF_BYPASS (RF_BYPASS)
    ) u_match_rt (
        .src_i     (MAX_REG_W'(id_rt)),
        .used_i    (id_rt_used),
        .ex_i      (ex_q),
        .mem_i     (mem_q),
        .wb_i      (wb_q),
        .stall_o   (stall_b),
        .fwd_sel_o (sel_b)
    );

    assign advance = ~mem_stall;

    always_comb begin
        stall_id = id_valid & ~flush & (stall_a | stall_b);

        issue      = '0;
        issue.v    = id_valid & ~stall_id & ~flush;
        if (issue.v) begin
            issue.rd   = MAX_REG_W'(id_rd);
            issue.wr   = id_wr;
            issue.load = id_load;
        end

        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        cnt_d   = cnt_q;

        if (advance) begin
            wb_d    = mem_q;
            mem_d   = ex_q;
            ex_d    = issue;
            fwd_a_d = issue.v ? sel_a : FWD_RF;
            fwd_b_d = issue.v ? sel_b : FWD_RF;
        end
        // a redirect kills EX even while memory holds the pipe
        if (flush) begin
            ex_d = '0;
        end

        if (stall_id && advance && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default forwarding config and
// a stall-only, no-bypass, 4-bit-counter config side by side.
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       v;
        logic [2:0] rs;
        logic       ru;
        logic [2:0] rt;
        logic       tu;
        logic [2:0] rd;
        logic       wr;
        logic       ld;
    } ins_t;

    logic       clk = 1'b0;
    logic       rst_n [2];
    logic       vld   [2];
    logic [2:0] rs    [2];
    logic       rsu   [2];
    logic [2:0] rt    [2];
    logic       rtu   [2];
    logic [2:0] rd    [2];
    logic       wr    [2];
    logic       ld    [2];
    logic       ms    [2];
    logic       fl    [2];

    logic        stall0, stall1;
    logic [1:0]  fa0, fb0, fa1, fb1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] selq[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_W(3), .FWD_EN(1'b1), .RF_BYPASS(1'b1), .CNT_W(16)
    ) u_fwd (
        .clk(clk), .rst_n(rst_n[0]), .id_valid(vld[0]),
        .id_rs(rs[0]), .id_rs_used(rsu[0]),
        .id_rt(rt[0]), .id_rt_used(rtu[0]),
        .id_rd(rd[0]), .id_wr(wr[0]), .id_load(ld[0]),
        .mem_stall(ms[0]), .flush(fl[0]),
        .stall_id(stall0), .fwd_a_sel(fa0), .fwd_b_sel(fb0),
        .stall_cnt(cnt0)
    );

    hazard_scoreboard #(
        .REG_W(3), .FWD_EN(1'b0), .RF_BYPASS(1'b0), .CNT_W(4)
    ) u_stl (
        .clk(clk), .rst_n(rst_n[1]), .id_valid(vld[1]),
        .id_rs(rs[1]), .id_rs_used(rsu[1]),
        .id_rt(rt[1]), .id_rt_used(rtu[1]),
        .id_rd(rd[1]), .id_wr(wr[1]), .id_load(ld[1]),
        .mem_stall(ms[1]), .flush(fl[1]),
        .stall_id(stall1), .fwd_a_sel(fa1), .fwd_b_sel(fb1),
        .stall_cnt(cnt1)
    );

    function automatic ins_t mk(
        input logic v, input logic [2:0] s1, input logic u1,
        input logic [2:0] s2, input logic u2,
        input logic [2:0] d, input logic w, input logic l
    );
        ins_t i;
        i.v = v; i.rs = s1; i.ru = u1; i.rt = s2; i.tu = u2;
        i.rd = d; i.wr = w; i.ld = l;
        return i;
    endfunction

    function automatic ins_t alu(input logic [2:0] d, input logic [2:0] s1,
                                 input logic [2:0] s2);
        return mk(1'b1, s1, 1'b1, s2, 1'b1, d, 1'b1, 1'b0);
    endfunction

    function automatic ins_t lw(input logic [2:0] d, input logic [2:0] s1);
        return mk(1'b1, s1, 1'b1, 3'd0, 1'b0, d, 1'b1, 1'b1);
    endfunction

    function automatic ins_t li(input logic [2:0] d);
        return mk(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, d, 1'b1, 1'b0);
    endfunction

    function automatic ins_t nop();
        return mk(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endfunction

    function automatic logic obs_stall(input int k);
        return (k == 0) ? stall0 : stall1;
    endfunction

    function automatic logic [3:0] obs_sel(input int k);
        return (k == 0) ? {fa0, fb0} : {fa1, fb1};
    endfunction

    function automatic logic [31:0] obs_cnt(input int k);
        return (k == 0) ? 32'(cnt0) : 32'(cnt1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input ins_t i, input logic m,
                         input logic f);
        vld[k] = i.v; rs[k] = i.rs; rsu[k] = i.ru;
        rt[k] = i.rt; rtu[k] = i.tu; rd[k] = i.rd;
        wr[k] = i.wr; ld[k] = i.ld; ms[k] = m; fl[k] = f;
    endtask

    // one ID cycle: stall is checked now, the select after the edge
    task automatic step(input int k, input ins_t i, input logic m,
                        input logic f, input logic es,
                        input logic [3:0] esel, input string tag);
        logic [3:0] e;
        drive(k, i, m, f);
        #3;
        chk({tag, ".stall"}, 32'(obs_stall(k)), 32'(es));
        selq.push_back(esel);
        @(posedge clk);
        #1;
        e = selq.pop_front();
        chk({tag, ".sel"}, 32'(obs_sel(k)), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            drive(k, nop(), 1'b0, 1'b0);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst.stall", 32'(obs_stall(k)), 32'd0);
            chk("rst.sel", 32'(obs_sel(k)), 32'd0);
            chk("rst.cnt", obs_cnt(k), 32'd0);
        end
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back ALU forwarding from EX/MEM
        step(0, alu(1, 2, 3), 0, 0, 0, 4'b0000, "t1_w");
        step(0, alu(2, 1, 3), 0, 0, 0, 4'b0100, "t1_fwd");
        for (int j = 0; j < 3; j++) step(0, nop(), 0, 0, 0, 4'b0000, "drain");

        // load-use: one bubble then MEM/WB forward on both sources
        step(0, lw(4, 5), 0, 0, 0, 4'b0000, "t2_ld");
        step(0, alu(5, 4, 4), 0, 0, 1, 4'b0000, "t2_lu_stall");
        step(0, alu(5, 4, 4), 0, 0, 0, 4'b1010, "t2_lu_fwd");
        chk("t2_cnt", obs_cnt(0), 32'd1);
        for (int j = 0; j < 3; j++) step(0, nop(), 0, 0, 0, 4'b0000, "drain");

        // youngest writer, MEM-only, WB-only and unused-source cases
        step(0, alu(2, 1, 3), 0, 0, 0, 4'b0000, "t3_w1");
        step(0, alu(2, 1, 3), 0, 0, 0, 4'b0000, "t3_w2");
        step(0, alu(6, 2, 0), 0, 0, 0, 4'b0100, "t3_young");
        step(0, alu(2, 1, 3), 0, 0, 0, 4'b0000, "t3_w3");
        step(0, nop(), 0, 0, 0, 4'b0000, "t3_gap");
        step(0, alu(6, 2, 0), 0, 0, 0, 4'b1000, "t3_mem");
        step(0, alu(7, 2, 2), 0, 0, 0, 4'b0000, "t3_wb");
        step(0, mk(1, 3'd6, 0, 3'd7, 1, 3'd1, 1, 0), 0, 0, 0, 4'b0001,
             "t3_unused");
        for (int j = 0; j < 3; j++) step(0, nop(), 0, 0, 0, 4'b0000, "drain");

        // flush on a load-use cycle, then memory wait freezing state
        step(0, lw(4, 5), 0, 0, 0, 4'b0000, "t5_ld");
        step(0, alu(5, 4, 4), 0, 1, 0, 4'b0000, "t5_flush");
        chk("t5_flush_cnt", obs_cnt(0), 32'd1);
        step(0, alu(5, 4, 4), 0, 0, 0, 4'b1010, "t5_after");
        for (int j = 0; j < 4; j++) step(0, alu(6, 5, 1), 1, 0, 0, 4'b1010, "t5_hold");
        step(0, alu(6, 5, 1), 0, 0, 0, 4'b0100, "t5_release");
        step(0, lw(3, 0), 0, 0, 0, 4'b0000, "t5_ld2");
        for (int j = 0; j < 2; j++) step(0, alu(1, 3, 3), 1, 0, 1, 4'b0000, "t5_ms_stall");
        chk("t5_ms_nocount", obs_cnt(0), 32'd1);
        step(0, alu(1, 3, 3), 0, 0, 1, 4'b0000, "t5_lu_stall");
        step(0, alu(1, 3, 3), 0, 0, 0, 4'b1010, "t5_lu_fwd");
        chk("t5_cnt", obs_cnt(0), 32'd2);
        step(0, alu(2, 1, 1), 1, 1, 0, 4'b1010, "t5_flush_ms");
        step(0, alu(2, 1, 1), 0, 0, 0, 4'b0000, "t5_ex_killed");
        for (int j = 0; j < 3; j++) step(0, nop(), 0, 0, 0, 4'b0000, "drain");
        drive(0, nop(), 1'b0, 1'b0);

        // stall-only, no bypass: three stall cycles per RAW pair
        step(1, alu(1, 2, 3), 0, 0, 0, 4'b0000, "t4_w");
        for (int j = 0; j < 3; j++) step(1, alu(2, 1, 3), 0, 0, 1, 4'b0000, "t4_stall");
        step(1, alu(2, 1, 3), 0, 0, 0, 4'b0000, "t4_issue");
        chk("t4_cnt", obs_cnt(1), 32'd3);

        // keep stalling until the 4-bit counter must saturate
        for (int n = 1; n <= 6; n++) begin
            step(1, li(1), 0, 0, 0, 4'b0000, "t6_w");
            for (int j = 0; j < 3; j++)
                step(1, mk(1, 3'd1, 1, 3'd0, 0, 3'd5, 1, 0), 0, 0, 1,
                     4'b0000, "t6_stall");
            step(1, mk(1, 3'd1, 1, 3'd0, 0, 3'd5, 1, 0), 0, 0, 0,
                 4'b0000, "t6_issue");
            chk("t6_sat", obs_cnt(1), (3 + 3 * n > 15) ? 32'd15 : 32'(3 + 3 * n));
        end

        // async reset in the middle of a stall
        step(1, li(1), 0, 0, 0, 4'b0000, "t6_rw");
        drive(1, mk(1, 3'd1, 1, 3'd0, 0, 3'd5, 1, 0), 1'b0, 1'b0);
        #3;
        chk("t6_pre_rst.stall", 32'(stall1), 32'd1);
        rst_n[1] = 1'b0;
        #1;
        chk("t6_rst.stall", 32'(stall1), 32'd0);
        chk("t6_rst.cnt", obs_cnt(1), 32'd0);
        chk("t6_rst.sel", 32'(obs_sel(1)), 32'd0);
        #2;
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_post_rst.cnt", obs_cnt(1), 32'd0);
        step(1, mk(1, 3'd1, 1, 3'd0, 0, 3'd5, 1, 0), 0, 0, 0, 4'b0000,
             "t6_rst_clear");
        drive(1, nop(), 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
